// File: rtl/sram_like_axi_bridge_if.sv
// Signal bundle between an SRAM-like initiator, the bridge and an AXI4-Lite slave.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface sram_like_axi_bridge_if;
   logic        s_req;
   logic        s_wr;
   logic [1:0]  s_size;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic        s_addr_ok;
   logic        s_data_ok;
   logic [31:0] s_rdata;
   logic [31:0] m_araddr;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rvalid;
   logic        m_rready;
   logic [31:0] m_awaddr;
   logic        m_awvalid;
   logic        m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid;
   logic        m_wready;
   logic [1:0]  m_bresp;
   logic        m_bvalid;
   logic        m_bready;

   modport master (
      input  s_req, s_wr, s_size, s_addr, s_wdata,
      output s_addr_ok, s_data_ok, s_rdata,
      output m_araddr, m_arvalid, input m_arready,
      input  m_rdata, m_rresp, m_rvalid, output m_rready,
      output m_awaddr, m_awvalid, input m_awready,
      output m_wdata, m_wstrb, m_wvalid, input m_wready,
      input  m_bresp, m_bvalid, output m_bready
   );

   modport slave (
      output s_req, s_wr, s_size, s_addr, s_wdata,
      input  s_addr_ok, s_data_ok, s_rdata,
      input  m_araddr, m_arvalid, output m_arready,
      output m_rdata, m_rresp, m_rvalid, input m_rready,
      input  m_awaddr, m_awvalid, output m_awready,
      input  m_wdata, m_wstrb, m_wvalid, output m_wready,
      output m_bresp, m_bvalid, input m_bready
   );
endinterface

// File: rtl/sram_like_axi_bridge.sv
// SRAM-like responder to single-beat AXI4-Lite master, one transaction outstanding.
// Define BRIDGE_RESP_REG_EN to register s_data_ok/s_rdata one cycle after the R/B handshake.
module sram_like_axi_bridge (
   input  logic                          clk,
   input  logic                          resetn,
   sram_like_axi_bridge_if.master        bus
);
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RD_AR  = 3'd1;
   localparam logic [2:0] ST_RD_R   = 3'd2;
   localparam logic [2:0] ST_WR_REQ = 3'd3;
   localparam logic [2:0] ST_WR_B   = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        accept_s, r_hs_s, b_hs_s;
   logic        resp_unused_s;

   // Byte-lane mask for a sub-word store; size 3 is treated as a full word.
   function automatic logic [3:0] byte_strb(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'd0:    return 4'b0001 << lane;
         2'd1:    return 4'b0011 << {lane[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   assign resp_unused_s = ^{bus.m_rresp, bus.m_bresp};
   assign r_hs_s = (state_q == ST_RD_R) && bus.m_rvalid;
   assign b_hs_s = (state_q == ST_WR_B) && bus.m_bvalid;

`ifdef BRIDGE_RESP_REG_EN
   logic resp_q, resp_d;

   // Hold off a new accept while the registered completion pulse is still showing.
   assign accept_s       = (state_q == ST_IDLE) && bus.s_req && !resp_q;
   assign resp_d         = r_hs_s || b_hs_s;
   assign bus.s_data_ok  = resp_q;
   assign bus.s_rdata    = rdata_q;

   // Registered completion pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resp_q <= 1'b0;
      end else begin
         resp_q <= resp_d;
      end
   end
`else
   assign accept_s       = (state_q == ST_IDLE) && bus.s_req;
   assign bus.s_data_ok  = r_hs_s || b_hs_s;
   assign bus.s_rdata    = r_hs_s ? bus.m_rdata : rdata_q;
`endif

   assign bus.s_addr_ok  = accept_s;
   assign bus.m_arvalid  = (state_q == ST_RD_AR);
   assign bus.m_rready   = (state_q == ST_RD_R);
   assign bus.m_awvalid  = (state_q == ST_WR_REQ) && !aw_done_q;
   assign bus.m_wvalid   = (state_q == ST_WR_REQ) && !w_done_q;
   assign bus.m_bready   = (state_q == ST_WR_B);
   assign bus.m_araddr   = {addr_q, 2'b00};
   assign bus.m_awaddr   = {addr_q, 2'b00};
   assign bus.m_wdata    = wdata_q;
   assign bus.m_wstrb    = wstrb_q;

   // Next-state and request-latch logic.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = r_hs_s ? bus.m_rdata : rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d   = bus.s_wr ? ST_WR_REQ : ST_RD_AR;
               addr_d    = bus.s_addr[31:2];
               wdata_d   = bus.s_wdata;
               wstrb_d   = bus.s_wr ? byte_strb(bus.s_size, bus.s_addr[1:0]) : 4'b0000;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_RD_AR: begin
            if (bus.m_arready) begin
               state_d = ST_RD_R;
            end else begin
               state_d = ST_RD_AR;
            end
         end
         ST_RD_R: begin
            if (bus.m_rvalid) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RD_R;
            end
         end
         ST_WR_REQ: begin
            // AW and W complete independently; leave only once both have handshaken.
            aw_done_d = aw_done_q || bus.m_awready;
            w_done_d  = w_done_q  || bus.m_wready;
            if (aw_done_d && w_done_d) begin
               state_d   = ST_WR_B;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end else begin
               state_d   = ST_WR_REQ;
            end
         end
         ST_WR_B: begin
            if (bus.m_bvalid) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WR_B;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         addr_q    <= 30'd0;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end
endmodule
